// File: rtl/conv_frame_ctrl_if.sv
// Handshake bundle for conv_frame_ctrl: input word stream, encoder hookup,
// and output symbol stream. The slave modport is the frame controller's view.
interface conv_frame_ctrl_if #(
  parameter int DATA_W = 8
);
  // input word stream
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_last;
  logic              in_ready;
  // encoder bit interface
  logic              enc_x;
  logic              enc_en;
  logic              enc_clr;
  logic [1:0]        enc_y;
  // symbol stream and status
  logic [1:0]        sym;
  logic              sym_valid;
  logic              sym_first;
  logic              sym_last;
  logic              out_ready;
  logic              frame_done;
  logic              overrun;

  modport master (
    output in_data, in_valid, in_last, enc_y, out_ready,
    input  in_ready, enc_x, enc_en, enc_clr, sym, sym_valid, sym_first,
           sym_last, frame_done, overrun
  );

  modport slave (
    input  in_data, in_valid, in_last, enc_y, out_ready,
    output in_ready, enc_x, enc_en, enc_clr, sym, sym_valid, sym_first,
           sym_last, frame_done, overrun
  );
endinterface

// File: rtl/conv_frame_ctrl.sv
// Frame sequencer for a rate-1/2 K=3 convolutional encoder. Serialises input
// words MSB-first into the encoder, appends TAIL_LEN zero flush bits, and
// forwards the encoder output as a backpressured symbol stream.
module conv_frame_ctrl #(
  parameter int DATA_W    = 8,
  parameter int MAX_WORDS = 16,
  parameter int TAIL_LEN  = 2
) (
  input  logic               clk,
  input  logic               reset,
  conv_frame_ctrl_if.slave   bus
);

  localparam int BIT_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int WORD_W = $clog2(MAX_WORDS + 1);
  localparam int TAIL_W = $clog2(TAIL_LEN) + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    TAIL  = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   shift_q, shift_d;
  logic                last_q, last_d;
  // starve: word boundary reached in SHIFT but no next word offered yet
  logic                starve_q, starve_d;
  logic [BIT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [WORD_W-1:0]   word_cnt_q, word_cnt_d;
  logic [TAIL_W-1:0]   tail_cnt_q, tail_cnt_d;
  logic                overrun_q, overrun_d;
  logic                frame_done_q, frame_done_d;

  logic in_ready_c, enc_x_c, enc_en_c, enc_clr_c;
  logic sym_valid_c, sym_first_c, sym_last_c;

  // Next-state, counter and handshake logic
  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    last_d       = last_q;
    starve_d     = starve_q;
    bit_cnt_d    = bit_cnt_q;
    word_cnt_d   = word_cnt_q;
    tail_cnt_d   = tail_cnt_q;
    overrun_d    = overrun_q;
    frame_done_d = 1'b0;
    in_ready_c   = 1'b0;
    enc_x_c      = 1'b0;
    enc_en_c     = 1'b0;
    enc_clr_c    = 1'b0;
    sym_valid_c  = 1'b0;
    sym_first_c  = 1'b0;
    sym_last_c   = 1'b0;

    unique case (state_q)
      IDLE: begin
        in_ready_c = 1'b1;
        enc_clr_c  = 1'b1;
        if (bus.in_valid) begin
          shift_d    = bus.in_data;
          last_d     = bus.in_last;
          word_cnt_d = WORD_W'(1);
          bit_cnt_d  = '0;
          starve_d   = 1'b0;
          state_d    = SHIFT;
        end
      end

      SHIFT: begin
        enc_x_c = shift_q[DATA_W-1];
        if (starve_q) begin
          in_ready_c = 1'b1;
          if (bus.in_valid) begin
            shift_d    = bus.in_data;
            last_d     = bus.in_last;
            word_cnt_d = word_cnt_q + WORD_W'(1);
            starve_d   = 1'b0;
          end
        end else begin
          sym_valid_c = 1'b1;
          sym_first_c = (word_cnt_q == WORD_W'(1)) && (bit_cnt_q == '0);
          enc_en_c    = bus.out_ready;
          if (bus.out_ready) begin
            shift_d = {shift_q[DATA_W-2:0], 1'b0};
            if (bit_cnt_q == BIT_W'(DATA_W - 1)) begin
              bit_cnt_d = '0;
              if (last_q) begin
                tail_cnt_d = '0;
                state_d    = TAIL;
              end else if (word_cnt_q == WORD_W'(MAX_WORDS)) begin
                overrun_d  = 1'b1;
                tail_cnt_d = '0;
                state_d    = TAIL;
              end else begin
                // next word is taken in the same cycle as the final bit so
                // back-to-back words leave no bubble in the symbol stream
                in_ready_c = 1'b1;
                if (bus.in_valid) begin
                  shift_d    = bus.in_data;
                  last_d     = bus.in_last;
                  word_cnt_d = word_cnt_q + WORD_W'(1);
                end else begin
                  starve_d = 1'b1;
                end
              end
            end else begin
              bit_cnt_d = bit_cnt_q + BIT_W'(1);
            end
          end
        end
      end

      TAIL: begin
        sym_valid_c = 1'b1;
        enc_en_c    = bus.out_ready;
        sym_last_c  = (tail_cnt_q == TAIL_W'(TAIL_LEN - 1));
        if (bus.out_ready) begin
          if (sym_last_c) begin
            frame_done_d = 1'b1;
            state_d      = IDLE;
          end else begin
            tail_cnt_d = tail_cnt_q + TAIL_W'(1);
          end
        end
      end

      default: state_d = IDLE;
    endcase

    // During reset the outputs take their idle-and-cleared values at once,
    // independent of whatever state the registers currently hold.
    if (reset) begin
      in_ready_c  = 1'b0;
      enc_en_c    = 1'b0;
      enc_x_c     = 1'b0;
      enc_clr_c   = 1'b1;
      sym_valid_c = 1'b0;
      sym_first_c = 1'b0;
      sym_last_c  = 1'b0;
    end
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      shift_q      <= '0;
      last_q       <= 1'b0;
      starve_q     <= 1'b0;
      bit_cnt_q    <= '0;
      word_cnt_q   <= '0;
      tail_cnt_q   <= '0;
      overrun_q    <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      last_q       <= last_d;
      starve_q     <= starve_d;
      bit_cnt_q    <= bit_cnt_d;
      word_cnt_q   <= word_cnt_d;
      tail_cnt_q   <= tail_cnt_d;
      overrun_q    <= overrun_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign bus.in_ready   = in_ready_c;
  assign bus.enc_x      = enc_x_c;
  assign bus.enc_en     = enc_en_c;
  assign bus.enc_clr    = enc_clr_c;
  assign bus.sym        = bus.enc_y;
  assign bus.sym_valid  = sym_valid_c;
  assign bus.sym_first  = sym_first_c;
  assign bus.sym_last   = sym_last_c;
  assign bus.frame_done = frame_done_q;
  assign bus.overrun    = overrun_q;

endmodule

// File: doc/conv_frame_ctrl.md
Name: conv_frame_ctrl

Overview:
- Frame sequencer for the rate-1/2, K=3 convolutional encoder (generators g0=111, g1=101).
- Accepts data words on a valid/ready input stream and serialises them MSB-first into the encoder's bit input.
- Appends K-1 zero tail bits to flush the trellis, then emits the 2-bit symbol stream with frame delimiters and backpressure.
- Sits between the packet source and the modulator/symbol FIFO.

Parameters:
- DATA_W, 8: bits per input word.
- MAX_WORDS, 16: maximum words per frame; overrun forces frame termination.
- TAIL_LEN, 2: zero flush bits appended per frame (K-1).

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high; clears all state
- in_data  in  DATA_W  input word
- in_valid  in  1  in_data valid
- in_last  in  1  word is last of frame
- in_ready  out  1  word accepted on in_valid&&in_ready
- enc_x  out  1  bit presented to encoder
- enc_en  out  1  encoder state advances at clk edge when high
- enc_clr  out  1  synchronous clear of encoder state to 00
- enc_y  in  2  encoder output, combinational from enc_x and encoder state ({g0,g1})
- sym  out  2  output symbol (= enc_y)
- sym_valid  out  1  sym valid
- sym_first  out  1  first symbol of frame
- sym_last  out  1  last tail symbol of frame
- out_ready  in  1  downstream accepts sym
- frame_done  out  1  one-cycle pulse after last symbol accepted
- overrun  out  1  sticky: frame exceeded MAX_WORDS words

Behaviour:
- Reset values: in_ready=0, enc_x=0, enc_en=0, enc_clr=1 during the reset cycle, sym_valid=0, sym_first=0, sym_last=0, frame_done=0, overrun=0. State is IDLE.
- States: IDLE, SHIFT, TAIL.
- IDLE:
  - in_ready=1, enc_clr=1.
  - On in_valid: latch in_data into shift_reg, latch in_last, word_cnt=1, bit_cnt=0, go to SHIFT.
- SHIFT:
  - enc_x=shift_reg[DATA_W-1], sym_valid=1.
  - sym_first=1 only on bit 0 of word 1.
  - Transfer = sym_valid&&out_ready. enc_en=transfer. shift_reg shifts left and bit_cnt increments only on transfer.
  - No transfer: all outputs hold stable; sym must not change while sym_valid&&!out_ready.
- Word boundary (transfer when bit_cnt==DATA_W-1):
  - If latched last=0 and word_cnt<MAX_WORDS: in_ready=1 combinationally in this cycle. If in_valid, load the next word with zero bubble, word_cnt++, stay in SHIFT. If !in_valid, hold in SHIFT with sym_valid=0 (stall state, enc_en=0) until in_valid.
  - If last=1: go to TAIL, tail_cnt=0.
  - If word_cnt==MAX_WORDS and last=0: set overrun, go to TAIL. Subsequent words of the oversized frame are accepted in IDLE as a new frame; no data is dropped silently.
- TAIL:
  - enc_x=0, sym_valid=1. enc_en=transfer, tail_cnt++ on transfer.
  - sym_last=1 when tail_cnt==TAIL_LEN-1.
  - On that transfer: go to IDLE, frame_done=1 next cycle.
- Frame length: symbols per frame = words×DATA_W+TAIL_LEN (10 for 1 word at DATA_W=8).
- in_ready is never 1 in TAIL.
- overrun clears only on reset.
- Reset mid-frame: immediate return to IDLE next edge. Encoder is cleared, no further symbols, partial frame discarded, no frame_done.
- Counters: bit_cnt is clog2(DATA_W) bits, word_cnt is clog2(MAX_WORDS+1) bits, tail_cnt is clog2(TAIL_LEN)+1 bits. No wrap within a legal frame.

Test Plan:
- Single word 0x80, in_last=1, out_ready=1 -> sym sequence 11,10,11,00,00,00,00,00,00,00. sym_first on symbol 1, sym_last on symbol 10, frame_done pulse 1 cycle later.
- Single word 0xFF, last=1 -> 11,01,10,10,10,10,10,10,01,11.
- Two-word frame 0x80 then 0x01 with in_valid held -> 18 contiguous sym_valid cycles, no bubble at word boundary. in_ready high exactly one cycle mid-frame.
- Random out_ready deassertion during 0xA5 frame -> symbol sequence identical to the out_ready=1 run, sym stable while stalled, enc_en never high when out_ready=0.
- 17 words with in_last=0 (MAX_WORDS=16) -> TAIL after word 16, overrun=1, 130 symbols. Word 17 starts a new frame.
- Reset asserted at bit 3 of a word -> next cycle sym_valid=0, in_ready=1, enc_clr=1. A new frame 0x80 reproduces the test 1 sequence exactly.
